popcount_seq: RTL

Parametrised, multi-cycle population counter. Accepts a WIDTH-bit word over a valid/ready handshake and counts either its ones or its zeros, CHUNK bits per clock, using a combinational chunk adder tree. Returns the result over a second valid/ready handshake. It is the general, pipelined-datapath successor to the fixed 9-bit full-adder bit counter in the lab4 arithmetic blocks, and is used wherever wide words must be counted without a single-cycle WIDTH-input adder tree.

---
 rtl/popcount_pkg.sv | 15 +
 rtl/chunk_popcount.sv | 42 ++++
 rtl/popcount_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/popcount_pkg.sv
// Shared types and helpers for the sequential population counter.
package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 to width inclusive.
  function automatic int cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/chunk_popcount.sv
// Combinational CHUNK-bit ones counter. Each input bit is folded into a
// carry-save (sum, carry) pair through a full-adder stage; the pair is then
// resolved by a single ripple adder. All arithmetic is modulo 2**PW, which is
// exact because the true count never exceeds CHUNK < 2**PW.
module chunk_popcount #(
  parameter int CHUNK = 8,
  parameter int PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [PW-1:0]    count
);

  logic [PW-1:0] cs_sum;
  logic [PW-1:0] cs_carry;
  logic [PW-1:0] cs_bit;
  logic [PW-1:0] nx_sum;
  logic [PW-1:0] nx_carry;
  logic          rc;

  // Carry-save reduction of all input bits, then ripple-add the final pair.
  always_comb begin
    cs_sum   = '0;
    cs_carry = '0;
    cs_bit   = '0;
    nx_sum   = '0;
    nx_carry = '0;
    rc       = 1'b0;
    count    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cs_bit   = PW'(bits[i]);
      nx_sum   = cs_sum ^ cs_carry ^ cs_bit;
      nx_carry = ((cs_sum & cs_carry) | (cs_sum & cs_bit) | (cs_carry & cs_bit)) << 1;
      cs_sum   = nx_sum;
      cs_carry = nx_carry;
    end
    for (int k = 0; k < PW; k++) begin
      count[k] = cs_sum[k] ^ cs_carry[k] ^ rc;
      rc       = (cs_sum[k] & cs_carry[k]) | (cs_sum[k] & rc) | (cs_carry[k] & rc);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: takes a WIDTH-bit word over valid/ready,
// counts ones (or zeros) CHUNK bits per clock and returns the total over a
// second valid/ready handshake.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a word
//   COUNT | one CHUNK slice summed per cycle, N cycles total
//   DONE  | out_valid high, out_count held until out_ready
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int  WIDTH = 32,
  parameter int  CHUNK = 8,
  localparam int CW    = cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_zeros,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count
);

  localparam int N  = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int PW = $clog2(CHUNK + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || WIDTH < 1 || ((CHUNK > 0) ? (WIDTH % CHUNK) : 1) != 0) begin : g_bad_cfg
    $error("popcount_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    acc;
  logic [CW-1:0]    acc_next;
  logic [IW-1:0]    idx;
  logic [PW-1:0]    chunk_cnt;

  chunk_popcount #(
    .CHUNK (CHUNK),
    .PW    (PW)
  ) u_chunk (
    .bits  (shreg[CHUNK-1:0]),
    .count (chunk_cnt)
  );

  // Running total including the slice currently at the bottom of shreg.
  assign acc_next = acc + CW'(chunk_cnt);

  // Sequencer, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_count <= '0;
      acc       <= '0;
      shreg     <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Zeros mode is just ones counting on the inverted word.
            shreg    <= in_data ^ {WIDTH{in_zeros}};
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= COUNT;
          end
        end
        COUNT: begin
          acc   <= acc_next;
          shreg <= shreg >> CHUNK;
          idx   <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            out_count <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
